// File: rtl/gpr_writeback.sv
// Writeback queue between result producers and the register file write port.
// Optional read bypass from pending writes is built when GPR_WB_BYPASS_EN is defined.
module gpr_writeback #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_num,
  input  logic [31:0] in_data,
  output logic        reg_write,
  output logic [4:0]  num_write,
  output logic [31:0] data_write,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  output logic        rs_hit,
  output logic        rt_hit,
  output logic [31:0] rs_fwd,
  output logic [31:0] rt_fwd,
  output logic [4:0]  pending
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DepthCount = 5'(DEPTH);

  logic [4:0]    num_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [4:0]    count_q;
  logic          push, pop;

  assign in_ready = count_q < DepthCount;
  // Writes to r0 complete the handshake but never occupy a slot.
  assign push     = in_valid & in_ready & (in_num != 5'd0);
  assign pop      = count_q != 5'd0;
  assign pending  = count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        num_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        num_mem[tail_q]  <= in_num;
        data_mem[tail_q] <= in_data;
        tail_q           <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_write  <= 1'b0;
      num_write  <= '0;
      data_write <= '0;
    end else if (pop) begin
      reg_write  <= 1'b1;
      num_write  <= num_mem[head_q];
      data_write <= data_mem[head_q];
    end else begin
      reg_write  <= 1'b0;
    end
  end

`ifdef GPR_WB_BYPASS_EN
  // Scan oldest to newest so the tail-most matching entry wins; the output
  // register is older than every queued entry.
  function automatic logic [32:0] lookup(input logic [4:0] addr);
    logic          hit;
    logic [31:0]   fwd;
    logic [AW-1:0] idx;
    hit = 1'b0;
    fwd = '0;
    idx = head_q;
    if (addr != 5'd0) begin
      if (reg_write && (num_write == addr)) begin
        hit = 1'b1;
        fwd = data_write;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + AW'(i);
        if ((5'(i) < count_q) && (num_mem[idx] == addr)) begin
          hit = 1'b1;
          fwd = data_mem[idx];
        end
      end
    end
    return {hit, fwd};
  endfunction

  always_comb begin
    {rs_hit, rs_fwd} = lookup(rs);
    {rt_hit, rt_fwd} = lookup(rt);
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{rs, rt};
  assign rs_hit = 1'b0;
  assign rt_hit = 1'b0;
  assign rs_fwd = '0;
  assign rt_fwd = '0;
`endif

endmodule

// File: doc/gpr_writeback.md
GPR_WRITEBACK -- requirements
Module: gpr_writeback

Interface
REQ-001 Parameter: DEPTH, 4, number of queue entries; SHALL be a power of two, 2..16.
REQ-002 Port: clock  input  1  single clock; all state updates on posedge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  producer offers a writeback result.
REQ-005 Port: in_ready  output  1  block accepts a result this cycle.
REQ-006 Port: in_num  input  5  destination register number.
REQ-007 Port: in_data  input  32  result value.
REQ-008 Port: reg_write  output  1  write strobe to register file.
REQ-009 Port: num_write  output  5  register file write address.
REQ-010 Port: data_write  output  32  register file write data.
REQ-011 Port: rs, rt  input  5 each  register file read addresses, mirrored for bypass lookup.
REQ-012 Port: rs_hit, rt_hit  output  1 each  pending write exists for rs/rt.
REQ-013 Port: rs_fwd, rt_fwd  output  32 each  newest pending value for rs/rt.
REQ-014 Port: pending  output  5  number of queued entries (0..DEPTH).

Function
REQ-015 Handshake: transfer occurs on posedge when in_valid and in_ready are both 1; in_ready = (pending < DEPTH), combinational from state only.
REQ-016 Transfer with in_num = 0 SHALL be accepted and discarded: no enqueue, no pending change, no reg_write.
REQ-017 Transfer with in_num != 0 SHALL enqueue {in_num, in_data} at the tail, in FIFO order.
REQ-018 Drain: at each posedge with pending > 0, the head SHALL be popped into the output register: reg_write <= 1, num_write <= head num, data_write <= head data.
REQ-019 At each posedge with pending = 0, reg_write <= 0; num_write and data_write SHALL hold their values.
REQ-020 Latency: a result accepted into an empty queue at edge N appears on reg_write/num_write/data_write after edge N+1; the register file captures it at edge N+2.
REQ-021 Throughput: one drain per cycle; simultaneous enqueue and drain in the same edge SHALL leave pending unchanged.
REQ-022 Full: when pending = DEPTH, in_ready = 0; the drain at that edge does not raise in_ready until the following cycle.
REQ-023 Pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-024 reg_write SHALL never be 1 with num_write = 0.
REQ-025 Bypass candidates: all queue entries plus the output register while reg_write = 1; newest candidate wins (queue tail-most, then output register).
REQ-026 rs_hit/rt_hit SHALL be 0 when the address is 0 or no candidate matches; then rs_fwd/rt_fwd = 0.
REQ-027 Bypass outputs SHALL be combinational from current state, rs and rt; an entry transferred on the current edge is not visible until after that edge.

Reset
REQ-028 While reset = 1, asynchronously: pending = 0, pointers = 0, reg_write = 0, num_write = 0, data_write = 0, all hits 0.
REQ-029 Reset mid-drain SHALL discard all queued entries; no write to the register file occurs after reset assertion.
REQ-030 in_ready SHALL be 1 from the first cycle after reset deassertion.

Configuration
REQ-031 Macro GPR_WB_BYPASS_EN: when defined, bypass logic per REQ-025..REQ-027 is compiled in.
REQ-032 When GPR_WB_BYPASS_EN is undefined, rs_hit = rt_hit = 0 and rs_fwd = rt_fwd = 0 constantly; queue and drain behaviour unchanged.

Verification
REQ-033 Reset, then enqueue {5, 0x1234_5678} once -> reg_write=1, num_write=5, data_write=0x12345678 exactly one cycle after acceptance edge, then reg_write=0.
REQ-034 Enqueue {0, 0xDEAD_BEEF} -> in_ready stays 1, pending stays 0, reg_write never asserts.
REQ-035 Stall the drain path by filling 4 entries in back-to-back cycles while also pushing a 5th (DEPTH=4, burst faster than drain not possible, so hold in_valid 6 cycles with distinct data) -> pending never exceeds 4, all writes emerge in order 1,2,3,4,... with no loss across pointer wrap.
REQ-036 With bypass enabled, queue {7,0x11} then {7,0x22}, rs=7 -> rs_hit=1, rs_fwd=0x22 until both drained, then rs_hit=0; rs=0 -> rs_hit=0.
REQ-037 Queue 3 entries, assert reset between drains -> outputs zero immediately, pending=0, no further reg_write pulses after reset.
REQ-038 Build without GPR_WB_BYPASS_EN, repeat REQ-036 stimulus -> rs_hit=0, rs_fwd=0; write sequence identical to bypass build.
